// File: rtl/sixteen_bit_seq_divider_module.sv
// Restoring divider: one quotient bit per clock behind a start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module sixteen_bit_seq_divider_module #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_it;
  logic [WIDTH-1:0] q_it;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;

`ifdef DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      work_q      <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      work_q      <= work_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    work_d      = work_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;

    // The stored remainder never needs its top bit: a restore only happens
    // when the shifted value is below the divisor, which fits in WIDTH bits.
    rem_sh = {rem_q, work_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_it = trial[WIDTH-1:0];
      q_it   = {work_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_it = rem_sh[WIDTH-1:0];
      q_it   = {work_q[WIDTH-2:0], 1'b0};
    end

`ifdef DIVIDER_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    a_mag     = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag     = divisor[WIDTH-1]  ? -divisor  : divisor;
    fin_q     = neg_quo_q ? -q_it   : q_it;
    fin_r     = neg_rem_q ? -rem_it : rem_it;
`else
    a_mag     = dividend;
    b_mag     = divisor;
    fin_q     = q_it;
    fin_r     = rem_it;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dz_d        = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = '0;
            work_d  = a_mag;
            dvs_d   = b_mag;
            cnt_d   = '0;
`ifdef DIVIDER_SIGNED_EN
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
`endif
          end
        end
      end
      RUN: begin
        rem_d  = rem_it;
        work_d = q_it;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d     = DONE;
          quotient_d  = fin_q;
          remainder_d = fin_r;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_sixteen_bit_seq_divider_module.sv
// Directed and random division requests checked against a queued reference model.
module tb_sixteen_bit_seq_divider_module;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sq[$];
  int   checks = 0;
  int   fails  = 0;

  sixteen_bit_seq_divider_module #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa;
    int   sb;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
`else
      sa = int'(a);
      sb = int'(b);
`endif
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
      e.dz = 1'b0;
      e.lat = W + 1;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sq.push_back(model(a, b));
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check("busy after accept", busy, 1);
  endtask

  task automatic wait_result(input string tag, input int k0);
    int   k;
    exp_t e;
    k = k0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done seen"}, done, 1);
    check({tag, " queue nonempty"}, sq.size() > 0, 1);
    if (sq.size() > 0) begin
      e = sq.pop_front();
      check({tag, " latency"}, k, e.lat);
      check({tag, " quotient"}, quotient, e.q);
      check({tag, " remainder"}, remainder, e.r);
      check({tag, " div_by_zero"}, div_by_zero, e.dz);
    end
    @(negedge clk);
    check({tag, " done single pulse"}, done, 0);
    check({tag, " busy released"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    wait_result(tag, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("100/7", 16'd100, 16'd7);
    run_op("ffff/1", 16'hFFFF, 16'h0001);
    run_op("1234/ffff", 16'h1234, 16'hFFFF);
    run_op("ab/0", 16'h00AB, 16'h0000);
    run_op("after dz", 16'd1000, 16'd33);

    // A second start mid-RUN must not disturb the operation in flight.
    issue(16'd5000, 16'd9);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd77; divisor = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_result("start ignored", 6);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no extra done", seen, 0);

    // Reset in the middle of RUN drops the partial result.
    issue(16'h5555, 16'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check("mid reset quotient", quotient, 0);
    check("mid reset remainder", remainder, 0);
    check("mid reset div_by_zero", div_by_zero, 0);
    void'(sq.pop_back());
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("no done after reset", seen, 0);
    run_op("after reset", 16'hBEEF, 16'h0123);

`ifdef DIVIDER_SIGNED_EN
    run_op("-7/2", 16'hFFF9, 16'h0002);
    run_op("min/-1", 16'h8000, 16'hFFFF);
    run_op("7/-2", 16'h0007, 16'hFFFE);
`endif

    for (int i = 0; i < 6; i++) begin
      run_op("random", W'($urandom), W'($urandom_range(0, (i < 3) ? 255 : 65535)));
    end

    // Back-to-back accept on the first idle cycle after done.
    issue(16'd999, 16'd10);
    wait_result("b2b first", 1);
    run_op("b2b second", 16'd65000, 16'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
